seg_field_display: RTL and testbench

//  Parametrised driver for pairs of 7-segment digits: NUM_FIELDS binary fields (0..99) -> two digits each.

---
 rtl/seg_field_display_pkg.sv | 48 ++++
 rtl/seg_field_display_if.sv | 15 +
 rtl/seg_field_display_encoder.sv | 15 +
 rtl/seg_field_display.sv | 164 ++++++++++++++++
 tb/tb_seg_field_display.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/seg_field_display_pkg.sv
// Shared types and constants for the seven-segment field display: FSM states,
// widths, segment patterns {g,f,e,d,c,b,a} (1 = lit) and the BCD lookup.
package seg_field_display_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SNAP,
    LOAD,
    SHIFT,
    STORE,
    DONE
  } state_e;

  localparam int FIELD_W = 7;
  localparam int DIGIT_W = 7;

  localparam logic [DIGIT_W-1:0] SEG_BLANK = 7'b0000000;
  localparam logic [DIGIT_W-1:0] SEG_DASH  = 7'b1000000;

  localparam logic [DIGIT_W-1:0] SEG_0 = 7'b0111111;
  localparam logic [DIGIT_W-1:0] SEG_1 = 7'b0000110;
  localparam logic [DIGIT_W-1:0] SEG_2 = 7'b1011011;
  localparam logic [DIGIT_W-1:0] SEG_3 = 7'b1001111;
  localparam logic [DIGIT_W-1:0] SEG_4 = 7'b1100110;
  localparam logic [DIGIT_W-1:0] SEG_5 = 7'b1101101;
  localparam logic [DIGIT_W-1:0] SEG_6 = 7'b1111101;
  localparam logic [DIGIT_W-1:0] SEG_7 = 7'b0000111;
  localparam logic [DIGIT_W-1:0] SEG_8 = 7'b1111111;
  localparam logic [DIGIT_W-1:0] SEG_9 = 7'b1101111;

  // Nibbles 10..15 cannot come out of the converter; they render dark.
  function automatic logic [DIGIT_W-1:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg_field_display_if.sv
// Field/segment bus between the timer core (master) and the display driver (slave).
interface seg_field_display_if
  import seg_field_display_pkg::*;
#(
  parameter int NUM_FIELDS = 3
);
  logic [FIELD_W*NUM_FIELDS-1:0]   field_val;
  logic [NUM_FIELDS-1:0]           flash;
  logic                            blank_all;
  logic [2*DIGIT_W*NUM_FIELDS-1:0] seg_out;
  logic                            sweep_done;

  modport master (output field_val, flash, blank_all, input seg_out, sweep_done);
  modport slave  (input field_val, flash, blank_all, output seg_out, sweep_done);
endinterface

// File: rtl/seg_field_display_encoder.sv
// Combinational BCD digit -> seven-segment pattern; dash wins over blank.
module seg7_digit_encoder
  import seg_field_display_pkg::*;
(
  input  logic [3:0]         bcd_i,
  input  logic               blank_i,
  input  logic               dash_i,
  output logic [DIGIT_W-1:0] seg_o
);
  always_comb begin
    if (dash_i)       seg_o = SEG_DASH;
    else if (blank_i) seg_o = SEG_BLANK;
    else              seg_o = bcd_to_seg(bcd_i);
  end
endmodule

// File: rtl/seg_field_display.sv
// Two-digit seven-segment driver for NUM_FIELDS binary fields via one shared serial
// double-dabble converter, with per-field blink. Option: LEADING_ZERO_BLANK_EN.
module seg_field_display
  import seg_field_display_pkg::*;
#(
  parameter int NUM_FIELDS = 3,
  parameter int BLINK_DIV  = 25_000_000
) (
  input logic               clk,
  input logic               reset,
  seg_field_display_if.slave bus
);
  localparam int IDX_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int BC_W  = $clog2(BLINK_DIV);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [FIELD_W-1:0]   shift_q, shift_d;
  logic [7:0]           bcd_q, bcd_d;
  logic [2:0]           cnt_q, cnt_d;
  logic                 snap_en, store_en, sweep_done_w;

  logic [FIELD_W-1:0]   shadow_q [NUM_FIELDS];
  logic [3:0]           tens_q   [NUM_FIELDS];
  logic [3:0]           ones_q   [NUM_FIELDS];
  logic [NUM_FIELDS-1:0] ovf_q;

  logic [BC_W-1:0]      blink_cnt_q;
  logic                 blink_phase_q;

  logic [DIGIT_W-1:0]   enc_hi_w [NUM_FIELDS];
  logic [DIGIT_W-1:0]   enc_lo_w [NUM_FIELDS];
  logic [2*DIGIT_W*NUM_FIELDS-1:0] seg_q, seg_d;

  function automatic logic [7:0] dabble_adjust(input logic [7:0] b);
    logic [7:0] r;
    r = b;
    if (r[3:0] >= 4'd5) r[3:0] = r[3:0] + 4'd3;
    if (r[7:4] >= 4'd5) r[7:4] = r[7:4] + 4'd3;
    return r;
  endfunction

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    bcd_d        = bcd_q;
    cnt_d        = cnt_q;
    snap_en      = 1'b0;
    store_en     = 1'b0;
    sweep_done_w = 1'b0;
    unique case (state_q)
      IDLE: state_d = SNAP;
      SNAP: begin
        snap_en = 1'b1;
        state_d = LOAD;
      end
      LOAD: begin
        shift_d = shadow_q[idx_q];
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        bcd_d   = {dabble_adjust(bcd_q)[6:0], shift_q[FIELD_W-1]};
        shift_d = {shift_q[FIELD_W-2:0], 1'b0};
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd6) state_d = STORE;
      end
      STORE: begin
        store_en = 1'b1;
        if (idx_q == IDX_W'(NUM_FIELDS - 1)) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = LOAD;
        end
      end
      DONE: begin
        sweep_done_w = 1'b1;
        idx_d        = '0;
        state_d      = SNAP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end

  // Shadow copy freezes the inputs for a whole sweep; overflow is judged on it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_FIELDS; i++) begin
        shadow_q[i] <= '0;
        tens_q[i]   <= '0;
        ones_q[i]   <= '0;
      end
      ovf_q <= '0;
    end else begin
      if (snap_en) begin
        for (int i = 0; i < NUM_FIELDS; i++) shadow_q[i] <= bus.field_val[FIELD_W*i +: FIELD_W];
      end
      if (store_en) begin
        tens_q[idx_q] <= bcd_q[7:4];
        ones_q[idx_q] <= bcd_q[3:0];
        ovf_q[idx_q]  <= (shadow_q[idx_q] > 7'd99);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (blink_cnt_q == BC_W'(BLINK_DIV - 1)) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= ~blink_phase_q;
    end else begin
      blink_cnt_q   <= blink_cnt_q + BC_W'(1);
    end
  end

  for (genvar g = 0; g < NUM_FIELDS; g++) begin : g_field
    logic hi_blank;
`ifdef LEADING_ZERO_BLANK_EN
    assign hi_blank = (tens_q[g] == 4'd0);
`else
    assign hi_blank = 1'b0;
`endif
    seg7_digit_encoder u_hi (.bcd_i(tens_q[g]), .blank_i(hi_blank), .dash_i(ovf_q[g]), .seg_o(enc_hi_w[g]));
    seg7_digit_encoder u_lo (.bcd_i(ones_q[g]), .blank_i(1'b0),     .dash_i(ovf_q[g]), .seg_o(enc_lo_w[g]));
  end

  always_comb begin
    seg_d = '0;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      if (!(bus.blank_all || (bus.flash[i] && blink_phase_q)))
        seg_d[2*DIGIT_W*i +: 2*DIGIT_W] = {enc_hi_w[i], enc_lo_w[i]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) seg_q <= '0;
    else       seg_q <= seg_d;
  end

  assign bus.seg_out    = seg_q;
  assign bus.sweep_done = sweep_done_w;

endmodule

// File: tb/tb_seg_field_display.sv
// Self-checking bench for seg_field_display: randomized fields/flash/blank against a
// schedule-based behavioural model, plus literal checks around reset and the first sweep.
module tb_seg_field_display;
  localparam int NF    = 3;
  localparam int BD    = 8;
  localparam int SWEEP = 2 + 9 * NF;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seg_field_display_if #(.NUM_FIELDS(NF)) bus ();
  seg_field_display #(.NUM_FIELDS(NF), .BLINK_DIV(BD)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [6:0] dig_seg(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [13:0] fld_seg(input int v);
    logic [6:0] hi, lo;
    if (v > 99) return {7'h40, 7'h40};
    hi = dig_seg(v / 10);
    lo = dig_seg(v % 10);
`ifdef LEADING_ZERO_BLANK_EN
    if (v / 10 == 0) hi = 7'h00;
`endif
    return {hi, lo};
  endfunction

  // Model: t counts clock edges since reset release. Snapshot lands on edge 2 of
  // every sweep, field i becomes visible in the display regs on edge 11+9i.
  int               t;
  int               disp [NF];
  int               snap [NF];
  logic [14*NF-1:0] exp_seg;
  logic             exp_done;
  bit               armed = 1'b0;
  int               m_u;
  bit               m_ph;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      t = 0;
      armed = 1'b1;
      exp_seg = '0;
      exp_done = 1'b0;
      for (int i = 0; i < NF; i++) begin
        disp[i] = 0;
        snap[i] = 0;
      end
    end else begin
      t = t + 1;
      m_ph = (((t - 1) / BD) % 2) == 1;
      for (int i = 0; i < NF; i++)
        exp_seg[14*i +: 14] = (bus.blank_all || (bus.flash[i] && m_ph)) ? 14'h0 : fld_seg(disp[i]);
      if (t >= 2) begin
        m_u = (t - 2) % SWEEP;
        if (m_u == 0) begin
          for (int i = 0; i < NF; i++) snap[i] = int'(bus.field_val[7*i +: 7]);
        end else if (m_u >= 9 && (m_u - 9) % 9 == 0 && (m_u - 9) / 9 < NF) begin
          disp[(m_u - 9) / 9] = snap[(m_u - 9) / 9];
        end
      end
      exp_done = (t >= SWEEP) && ((t - SWEEP) % SWEEP == 0);
    end
  end

  always @(negedge clk) begin
    if (armed && !reset) begin
      chk("seg_out", 64'(bus.seg_out), 64'(exp_seg));
      chk("sweep_done", 64'(bus.sweep_done), 64'(exp_done));
    end
  end

  task automatic set_fields(input int a, input int b, input int c);
    bus.field_val = {7'(c), 7'(b), 7'(a)};
  endtask

  task automatic wait_t(input int target);
    int guard = 0;
    while (t < target && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (t < target) chk("wait_t_timeout", 64'(t), 64'(target));
  endtask

  // From a reset release at a negedge: sweep_done must rise after edge SWEEP and
  // the full "59","07","00" pattern must reach the pins one edge later.
  task automatic first_sweep();
    int n = 0;
    bit seen = 1'b0;
    logic [41:0] want;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      if (bus.sweep_done) seen = 1'b1;
    end
    chk("first_done_latency", 64'(n), 64'd29);
    @(negedge clk);
`ifdef LEADING_ZERO_BLANK_EN
    want = {7'h6D, 7'h6F, 7'h00, 7'h07, 7'h00, 7'h3F};
`else
    want = {7'h6D, 7'h6F, 7'h3F, 7'h07, 7'h3F, 7'h3F};
`endif
    chk("first_sweep_digits", 64'(bus.seg_out), 64'(want));
  endtask

  int specials [6] = '{0, 9, 10, 99, 100, 127};

  initial begin
    reset = 1'b1;
    bus.blank_all = 1'b0;
    bus.flash = '0;
    set_fields(0, 7, 59);
    repeat (3) @(negedge clk);
    chk("reset_seg_out", 64'(bus.seg_out), 64'd0);
    chk("reset_sweep_done", 64'(bus.sweep_done), 64'd0);
    reset = 1'b0;
    first_sweep();

    // Boundary values rotated across fields, one set per sweep, then random sweeps.
    for (int k = 0; k < 6; k++) begin
      set_fields(specials[k % 6], specials[(k + 1) % 6], specials[(k + 2) % 6]);
      repeat (SWEEP) @(negedge clk);
    end
    for (int k = 0; k < 4; k++) begin
      set_fields($urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 99));
      repeat (SWEEP) @(negedge clk);
    end

    // Middle field blinks over steady values.
    set_fields(42, 17, 88);
    bus.flash = 3'b010;
    repeat (70) @(negedge clk);
    bus.flash = '0;

    // Inputs churning mid-sweep.
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0)
        set_fields($urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 127));
    end

    // Random flash and occasional blanking.
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      bus.flash = 3'($urandom_range(0, 7));
      bus.blank_all = ($urandom_range(0, 7) == 0);
    end
    bus.blank_all = 1'b0;
    bus.flash = '0;

    // Long blank, conversion keeps running.
    set_fields(3, 64, 120);
    bus.blank_all = 1'b1;
    repeat (40) @(negedge clk);
    bus.blank_all = 1'b0;
    repeat (35) @(negedge clk);

    // Reset during the shift of field 1, then a clean first sweep.
    set_fields(0, 7, 59);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_t(14);
    reset = 1'b1;
    #1;
    chk("midsweep_reset_seg_out", 64'(bus.seg_out), 64'd0);
    chk("midsweep_reset_done", 64'(bus.sweep_done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    first_sweep();
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
